// File: rtl/router_pkg.sv
// router_pkg: shared state type, LFSR step and header packing for the router packet generator
package router_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_LEN_W  = 6;
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP} state_t;
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction
    function automatic logic [DEF_DATA_W-1:0] hdr_pack(input logic [DEF_LEN_W-1:0] len, input logic [DEF_ADDR_W-1:0] addr);
        return {len, addr};
    endfunction
endpackage

// File: rtl/router_lfsr8.sv
// router_lfsr8: 8-bit payload LFSR with seed load and advance enable
module router_lfsr8 import router_pkg::*; #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       adv,
    output logic [7:0] value
);
    // reseed on reset or burst start, step once per accepted payload byte
    always_ff @(posedge clk) begin
        if (rst || load) value <= SEED;
        else if (adv) value <= lfsr_next(value);
    end
endmodule

// File: rtl/router_pkt_gen.sv
// router_pkt_gen: burst packet source (header, LFSR payload, parity) honouring busy; ROUTER_PKTGEN_ERRINJ_EN adds parity error injection
module router_pkt_gen import router_pkg::*; #(
    parameter int         DATA_W     = DEF_DATA_W,
    parameter int         ADDR_W     = DEF_ADDR_W,
    parameter int         LEN_W      = DEF_LEN_W,
    parameter int         NUM_DEST   = 3,
    parameter logic [7:0] SEED       = 8'hA5,
    parameter int         GAP_CYCLES = 2,
    parameter int         CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_num_pkts,
`ifdef ROUTER_PKTGEN_ERRINJ_EN
    input  logic              err_inject,
`endif
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              cfg_err,
    output logic [CNT_W-1:0]  pkt_count
);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [ADDR_W:0] ND = (ADDR_W + 1)'(NUM_DEST);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   pkts_left;
    logic [LEN_W:0]     byte_cnt;
    logic [GW-1:0]      gap_cnt;
    logic [DATA_W-1:0]  parity, par_tx, hdr;
    logic [7:0]         lfsr;
    logic               cfg_ok, go, accept, last_byte, last_pkt, gap_last;

    assign cfg_ok    = {1'b0, cfg_addr} < ND;
    assign go        = state_q == S_IDLE && start && cfg_ok;
    assign accept    = !busy && (state_q == S_HEADER || state_q == S_PAYLOAD || state_q == S_PARITY);
    assign last_byte = (byte_cnt + 1'b1) == {1'b0, len_q};
    assign last_pkt  = pkts_left == CNT_W'(1);
    assign gap_last  = gap_cnt == GW'(GAP_CYCLES - 1);
    assign hdr       = hdr_pack(len_q, addr_q);

`ifdef ROUTER_PKTGEN_ERRINJ_EN
    logic inj_q;
    // error-inject flag is captured with the burst and applies to every packet in it
    always_ff @(posedge clk) begin
        if (rstn) inj_q <= 1'b0;
        else if (go) inj_q <= err_inject;
    end
    assign par_tx = parity ^ DATA_W'(inj_q);
`else
    assign par_tx = parity;
`endif

    router_lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rstn),
        .load (go),
        .adv  (state_q == S_PAYLOAD && !busy),
        .value(lfsr)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rstn) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    // next state and byte presented to the router; busy simply freezes the state
    always_comb begin
        state_d   = state_q;
        pkt_valid = 1'b0;
        data_out  = '0;
        case (state_q)
            S_IDLE:    if (go) state_d = S_HEADER;
            S_HEADER: begin
                pkt_valid = 1'b1;
                data_out  = hdr;
                if (!busy) state_d = len_q == '0 ? S_PARITY : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                pkt_valid = 1'b1;
                data_out  = lfsr;
                if (!busy && last_byte) state_d = S_PARITY;
            end
            S_PARITY: begin
                data_out = par_tx;
                if (!busy) state_d = last_pkt ? S_IDLE : (GAP_CYCLES == 0 ? S_HEADER : S_GAP);
            end
            S_GAP:     if (gap_last) state_d = S_HEADER;
            default:   state_d = S_IDLE;
        endcase
    end

    // burst config latch, byte/packet/gap counters, running parity and status pulses
    always_ff @(posedge clk) begin
        if (rstn) begin
            addr_q    <= '0;
            len_q     <= '0;
            pkts_left <= '0;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
            parity    <= '0;
            pkt_count <= '0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            done    <= state_q == S_PARITY && accept && last_pkt;
            cfg_err <= state_q == S_IDLE && start && !cfg_ok;
            if (go) begin
                addr_q    <= cfg_addr;
                len_q     <= cfg_len;
                pkts_left <= cfg_num_pkts == '0 ? CNT_W'(1) : cfg_num_pkts;
            end
            if (accept && state_q == S_HEADER) begin
                parity   <= hdr;
                byte_cnt <= '0;
            end
            if (accept && state_q == S_PAYLOAD) begin
                parity   <= parity ^ lfsr;
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (accept && state_q == S_PARITY) begin
                pkt_count <= pkt_count + 1'b1;
                pkts_left <= pkts_left - 1'b1;
                gap_cnt   <= '0;
            end
            if (state_q == S_GAP) gap_cnt <= gap_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_router_pkt_gen.sv
// tb_router_pkt_gen: directed self-checking bench for router_pkt_gen
module tb_router_pkt_gen;
    logic       clk = 1'b0;
    logic       rstn, start, busy;
    logic [1:0] cfg_addr;
    logic [5:0] cfg_len;
    logic [7:0] cfg_num_pkts;
    logic       pkt_valid, done, cfg_err;
    logic [7:0] data_out, pkt_count;
`ifdef ROUTER_PKTGEN_ERRINJ_EN
    logic       err_inject = 1'b0;
`endif
    int checks = 0;
    int failures = 0;

    router_pkt_gen dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .cfg_addr    (cfg_addr),
        .cfg_len     (cfg_len),
        .cfg_num_pkts(cfg_num_pkts),
`ifdef ROUTER_PKTGEN_ERRINJ_EN
        .err_inject  (err_inject),
`endif
        .busy        (busy),
        .pkt_valid   (pkt_valid),
        .data_out    (data_out),
        .done        (done),
        .cfg_err     (cfg_err),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_next(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic byte_chk(input string tag, input logic [7:0] d, input logic v);
        chk({tag, "_data"}, 32'(data_out), 32'(d));
        chk({tag, "_valid"}, 32'(pkt_valid), 32'(v));
    endtask

    task automatic kick(input logic [1:0] a, input logic [5:0] l, input logic [7:0] n);
        cfg_addr = a;
        cfg_len = l;
        cfg_num_pkts = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] m, par;
        rstn = 1'b1; start = 1'b0; busy = 1'b0;
        cfg_addr = '0; cfg_len = '0; cfg_num_pkts = '0;
        tick(); tick();
        rstn = 1'b0;
        byte_chk("rst", 8'h00, 1'b0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_cnt", 32'(pkt_count), 0);

        kick(2'd1, 6'd0, 8'd1);
        byte_chk("t1_hdr", 8'h01, 1'b1);
        tick(); byte_chk("t1_par", 8'h01, 1'b0);
        chk("t1_done_early", 32'(done), 0);
        tick(); chk("t1_done", 32'(done), 1);
        chk("t1_cnt", 32'(pkt_count), 1);
        tick(); chk("t1_done_pulse", 32'(done), 0);

        kick(2'd2, 6'd1, 8'd1);
        byte_chk("t2_hdr", 8'h06, 1'b1);
        tick(); byte_chk("t2_pay", 8'hA5, 1'b1);
        tick(); byte_chk("t2_par", 8'hA3, 1'b0);
        tick(); chk("t2_done", 32'(done), 1);
        chk("t2_cnt", 32'(pkt_count), 2);

        kick(2'd2, 6'd1, 8'd1);
        byte_chk("t3_hdr", 8'h06, 1'b1);
        tick(); byte_chk("t3_pay0", 8'hA5, 1'b1);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); byte_chk("t3_hold", 8'hA5, 1'b1);
        end
        busy = 1'b0;
        tick(); byte_chk("t3_par", 8'hA3, 1'b0);
        tick(); chk("t3_done", 32'(done), 1);
        chk("t3_cnt", 32'(pkt_count), 3);

        kick(2'd3, 6'd2, 8'd1);
        chk("t4_err", 32'(cfg_err), 1);
        byte_chk("t4_idle", 8'h00, 1'b0);
        tick(); chk("t4_err_pulse", 32'(cfg_err), 0);
        byte_chk("t4_still", 8'h00, 1'b0);
        chk("t4_cnt", 32'(pkt_count), 3);

        kick(2'd2, 6'd14, 8'd3);
        m = 8'hA5;
        for (int p = 0; p < 3; p++) begin
            byte_chk("t5_hdr", 8'h3A, 1'b1);
            par = 8'h3A;
            for (int i = 0; i < 14; i++) begin
                tick(); byte_chk("t5_pay", m, 1'b1);
                par ^= m;
                m = model_next(m);
            end
            tick(); byte_chk("t5_par", par, 1'b0);
            chk("t5_nodone", 32'(done), 0);
            if (p < 2) begin
                for (int g = 0; g < 2; g++) begin
                    tick(); byte_chk("t5_gap", 8'h00, 1'b0);
                    chk("t5_gap_done", 32'(done), 0);
                end
                tick();
            end
        end
        tick(); chk("t5_done", 32'(done), 1);
        chk("t5_cnt", 32'(pkt_count), 6);
        tick(); chk("t5_done_pulse", 32'(done), 0);

        kick(2'd1, 6'd3, 8'd2);
        byte_chk("t6_hdr", 8'h0D, 1'b1);
        tick(); byte_chk("t6_p0", 8'hA5, 1'b1);
        tick(); byte_chk("t6_p1", 8'h4A, 1'b1);
        tick(); byte_chk("t6_p2", 8'h95, 1'b1);
        tick(); byte_chk("t6_par", 8'h77, 1'b0);
        tick(); tick(); tick();
        byte_chk("t6_hdr2", 8'h0D, 1'b1);
        tick(); byte_chk("t6_p3", 8'h2A, 1'b1);
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        byte_chk("t6_rst", 8'h00, 1'b0);
        chk("t6_rst_cnt", 32'(pkt_count), 0);
        chk("t6_rst_done", 32'(done), 0);
        kick(2'd0, 6'd1, 8'd0);
        byte_chk("t6_hdr3", 8'h04, 1'b1);
        tick(); byte_chk("t6_pay", 8'hA5, 1'b1);
        tick(); byte_chk("t6_par2", 8'hA1, 1'b0);
        tick(); chk("t6_done", 32'(done), 1);
        chk("t6_cnt", 32'(pkt_count), 1);

`ifdef ROUTER_PKTGEN_ERRINJ_EN
        err_inject = 1'b1;
        kick(2'd2, 6'd1, 8'd1);
        err_inject = 1'b0;
        byte_chk("inj_hdr", 8'h06, 1'b1);
        tick(); byte_chk("inj_pay", 8'hA5, 1'b1);
        tick(); byte_chk("inj_par", 8'hA2, 1'b0);
        tick(); chk("inj_done", 32'(done), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
